// File: rtl/pow_seq_unit.sv
// Sequential integer power unit computing a ** b (Verilog semantics, truncated to WIDTH)
// by square-and-multiply. Optional undefined-result flag enabled by macro POW_UNDEF_FLAG_EN.
module pow_seq_unit #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [EXP_WIDTH-1:0] in_b,
  input  logic                 in_a_signed,
  input  logic                 in_b_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic                 out_undef
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_base;
  logic [EXP_WIDTH-1:0] r_exp;
  logic [EXP_WIDTH-1:0] w_exp_shift;
  logic [WIDTH-1:0]     w_special_y;
  logic                 w_accept;
  logic                 w_b_zero;
  logic                 w_b_neg;
  logic                 w_a_zero;
  logic                 w_a_one;
  logic                 w_a_minus1;
  logic                 w_special;

  assign in_ready    = (r_state == IDLE) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_b_zero    = (in_b == '0);
  assign w_b_neg     = in_b_signed && in_b[EXP_WIDTH-1];
  assign w_a_zero    = (in_a == '0);
  assign w_a_one     = (in_a == WIDTH'(1));
  assign w_a_minus1  = in_a_signed && (&in_a);
  assign w_special   = w_b_zero || w_b_neg;
  assign w_exp_shift = r_exp >> 1;

  // Results that need no iteration: zero exponent, or negative exponent (1/a**|b|).
  always_comb begin
    w_special_y = '0;
    if (w_b_zero || w_a_one) begin
      w_special_y = WIDTH'(1);
    end else if (w_a_minus1) begin
      w_special_y = in_b[0] ? '1 : WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_special ? DONE : RUN;
        end
      end
      // Stop on the edge that consumes the highest set exponent bit.
      RUN: begin
        if (w_exp_shift == '0) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_base <= '0;
      r_exp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc  <= w_special ? w_special_y : WIDTH'(1);
            r_base <= in_a;
            r_exp  <= in_b;
          end
        end
        RUN: begin
          if (r_exp[0]) begin
            r_acc <= r_acc * r_base;
          end
          r_base <= r_base * r_base;
          r_exp  <= w_exp_shift;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == DONE);
  assign out_y     = out_valid ? r_acc : '0;

`ifdef POW_UNDEF_FLAG_EN
  logic r_undef;

  // 0 ** negative is a division by zero, so it is reported as undefined.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_undef <= 1'b0;
    end else if (w_accept) begin
      r_undef <= w_b_neg && w_a_zero;
    end
  end

  assign out_undef = out_valid && r_undef;
`else
  assign out_undef = 1'b0;
`endif

endmodule

// File: tb/tb_pow_seq_unit.sv
// Self-checking bench for pow_seq_unit: directed corner cases plus random operands
// checked against an arithmetic reference model (honours POW_UNDEF_FLAG_EN).
module tb_pow_seq_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_a_signed = 1'b0;
  logic       in_b_signed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic       out_undef;

  int checks = 0;
  int errors = 0;

  pow_seq_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_undef(out_undef)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a ** b from its mathematical definition, with latency from the exponent's top bit.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic as, input logic bs,
                       output logic [7:0] y, output logic u, output int lat);
    int p;
    int hb;
    u   = 1'b0;
    lat = 1;
    if (b == 0) begin
      y = 8'd1;
    end else if (bs && b >= 128) begin
      if (a == 0) begin
        y = 8'd0;
`ifdef POW_UNDEF_FLAG_EN
        u = 1'b1;
`endif
      end else if (a == 1) begin
        y = 8'd1;
      end else if (as && a == 255) begin
        y = (b % 2 == 0) ? 8'd1 : 8'd255;
      end else begin
        y = 8'd0;
      end
    end else begin
      p = 1;
      for (int i = 0; i < int'(b); i++) p = (p * int'(a)) % 256;
      y  = p[7:0];
      hb = 0;
      for (int i = 0; i < 8; i++) if (b[i]) hb = i;
      lat = hb + 2;
    end
  endtask

  task automatic doOp(input logic [7:0] a, input logic [7:0] b, input logic as, input logic bs,
                      input int hold, input string tag);
    logic [7:0] ey;
    logic       eu;
    int         elat;
    int         lat;
    model(a, b, as, bs, ey, eu, elat);
    @(negedge clk);
    in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs; in_valid = 1'b1;
    #1 check(32'(in_ready), 32'd1, {tag, " ready_before_accept"});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) lat = c;
      else check({23'd0, out_undef, out_y}, 32'd0, {tag, " idle_outputs_zero"});
    end
    check(32'(lat), 32'(elat), {tag, " latency"});
    check(32'(out_y), 32'(ey), {tag, " y"});
    check(32'(out_undef), 32'(eu), {tag, " undef"});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({22'd0, in_ready, out_valid, out_y}, {22'd0, 1'b0, 1'b1, ey}, {tag, " hold_stable"});
    end
    if (lat != 0) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({22'd0, in_ready, out_valid, out_y}, {22'd0, 1'b1, 1'b0, 8'd0}, {tag, " after_consume"});
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    // Reset behaviour
    @(negedge clk);
    check({22'd0, in_ready, out_valid, out_y}, 32'd0, "reset_outputs");
    check(32'(out_undef), 32'd0, "reset_undef");
    @(negedge clk);
    rst = 1'b0;
    #1 check(32'(in_ready), 32'd1, "ready_after_reset");

    // Directed cases
    doOp(8'd3,   8'd2,   1'b0, 1'b0, 0, "u3pow2");
    doOp(8'hFD,  8'd3,   1'b1, 1'b1, 0, "sm3pow3");
    doOp(8'd2,   8'd200, 1'b0, 1'b0, 0, "u2pow200");
    doOp(8'hFE,  8'hFE,  1'b1, 1'b1, 0, "m2powm2");
    doOp(8'd1,   8'hFE,  1'b1, 1'b1, 0, "1powm2");
    doOp(8'hFF,  8'hFE,  1'b1, 1'b1, 0, "m1powm2");
    doOp(8'hFF,  8'hFD,  1'b1, 1'b1, 0, "m1powm3");
    doOp(8'hFF,  8'hFD,  1'b0, 1'b1, 0, "u255powm3");
    doOp(8'd0,   8'hFF,  1'b1, 1'b1, 0, "0powm1");
    doOp(8'd0,   8'd0,   1'b1, 1'b1, 0, "0pow0");
    doOp(8'd7,   8'd255, 1'b0, 1'b0, 0, "u7pow255");
    doOp(8'd5,   8'd1,   1'b0, 1'b0, 5, "backpressure");

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    in_a = 8'd2; in_b = 8'd200; in_a_signed = 1'b0; in_b_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check({30'd0, in_ready, out_valid}, 32'd0, "rst_midrun");
    @(posedge clk);
    #1 check({30'd0, in_ready, out_valid}, 32'd0, "rst_cycle_ready_low");
    @(negedge clk);
    rst = 1'b0;
    #1 check({30'd0, in_ready, out_valid}, 32'b10, "after_rst_ready");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check(32'(out_valid), 32'd0, "after_rst_no_output");
    end

    // Random operands against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n % 4 == 0) rb = 8'($urandom_range(0, 3));
      if (n % 7 == 0) ra = 8'($urandom_range(0, 1)) | (($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00);
      doOp(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
